// File: rtl/score_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module : score_engine_pkg
//  Brief  : Shared types and constants for the end-of-game scorer: FSM state
//           encoding, default term/penalty constants and the level bonus table.
//  Rev    : 1.0  initial release
// ============================================================================
package score_engine_pkg;

  // Default arithmetic constants of the scoring rule.
  localparam int c_MAX_TERM   = 3333;
  localparam int c_STEP       = 101;
  localparam int c_CAP        = 33;
  localparam int c_GRACE_STEP = 5;

  // Scorer FSM encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_MUL_T = 3'd2,
    S_MUL_P = 3'd3,
    S_SUM   = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  // Level bonus table; unknown levels earn nothing.
  function automatic int lvl_bonus(input int idx);
    case (idx)
      0:       return 0;
      1:       return 1515;
      2:       return 3333;
      default: return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_engine_if.sv
`default_nettype none
// ============================================================================
//  Module : score_engine_if
//  Brief  : Request/result bundle between game control (master) and the
//           scorer (slave).
//  Rev    : 1.0  initial release
// ============================================================================
interface score_engine_if #(
  parameter int LVL_W   = 2,
  parameter int CARD_W  = 6,
  parameter int SCORE_W = 14
);
  logic               enable;
  logic [LVL_W-1:0]   level;
  logic [CARD_W-1:0]  num_of_cards;
  logic [7:0]         discovered_pairs;
  logic [5:0]         seconds;
  logic [SCORE_W-1:0] points;
  logic               points_calculated;
  logic               new_record;
  logic [SCORE_W-1:0] best_points;

  modport master (
    output enable, level, num_of_cards, discovered_pairs, seconds,
    input  points, points_calculated, new_record, best_points
  );

  modport slave (
    input  enable, level, num_of_cards, discovered_pairs, seconds,
    output points, points_calculated, new_record, best_points
  );
endinterface
`default_nettype wire

// File: rtl/score_engine_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module : score_engine_seq_mult
//  Brief  : Serial shift-add multiplier, a_i x B (B a constant). The first
//           partial product is taken on the start edge, so the result is ready
//           after exactly A_W edges; done_o marks the cycle of the last edge.
//  Rev    : 1.0  initial release
// ============================================================================
module score_engine_seq_mult #(
  parameter int A_W = 6,
  parameter int P_W = 15,
  parameter int B   = 101
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           clr_i,
  input  wire logic           start_i,
  input  wire logic [A_W-1:0] a_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [P_W-1:0]      product_o
);
  localparam int CNT_W = $clog2(A_W + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [A_W-1:0]   a_q;
  logic [P_W-1:0]   b_q;
  logic [P_W-1:0]   acc_q;
  logic [P_W-1:0]   acc_d;

  // Next accumulator value for the current multiplier bit.
  always_comb begin
    acc_d = acc_q + (a_q[0] ? b_q : '0);
  end

  // Iteration registers: load on start, then shift one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else if (start_i && !busy_q) begin
      acc_q  <= a_i[0] ? P_W'(B) : '0;
      a_q    <= a_i >> 1;
      b_q    <= P_W'(B) << 1;
      cnt_q  <= CNT_W'(1);
      busy_q <= (A_W > 1);
    end else if (busy_q) begin
      acc_q <= acc_d;
      a_q   <= a_q >> 1;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(A_W - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q ? (cnt_q == CNT_W'(A_W - 1)) : (start_i && (A_W == 1));
  assign product_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/score_engine.sv
`default_nettype none
// ============================================================================
//  Module : score_engine
//  Brief  : End-of-game scorer. score = level bonus + (MAX_TERM - time penalty)
//           + (MAX_TERM - pairs penalty); both penalties come from one reused
//           serial multiplier. Tracks the best score per level.
//  Rev    : 1.0  initial release
// ============================================================================
module score_engine
  import score_engine_pkg::*;
#(
  parameter int NUM_LEVELS = 3,
  parameter int LVL_W      = 2,
  parameter int CARD_W     = 6,
  parameter int SCORE_W    = 14,
  parameter int FACT_W     = 6,
  parameter int MAX_TERM   = c_MAX_TERM,
  parameter int STEP       = c_STEP,
  parameter int CAP        = c_CAP,
  parameter int GRACE_STEP = c_GRACE_STEP
) (
  input  wire logic      clk,
  input  wire logic      rst,
  score_engine_if.slave  bus
);
  localparam int PW  = SCORE_W + 1;
  localparam int EXW = 16;

  state_t             state_q, state_d;
  logic [LVL_W-1:0]   lvl_q;
  logic               lvl_ok_q;
  logic [FACT_W-1:0]  ft_q, fp_q;
  logic [PW-1:0]      tp_q;
  logic [SCORE_W-1:0] points_q, points_d;
  logic               calc_q, calc_d;
  logic               rec_q, rec_d;
  logic [SCORE_W-1:0] best_q [NUM_LEVELS];

  logic               latch_en, best_we, mul_start, mul_clr, mul_busy, mul_done;
  logic [FACT_W-1:0]  mul_a;
  logic [PW-1:0]      mul_prod;

  logic               w_lvl_ok;
  logic [EXW-1:0]     w_grace, w_t_exc, w_half, w_p_exc;
  logic [FACT_W-1:0]  w_ft, w_fp;
  logic [PW-1:0]      w_bonus, w_term_t, w_term_p;
  logic [SCORE_W-1:0] w_score, w_best_cur, w_best_rd;
  logic               w_is_rec;

  // Saturating add of two non-negative terms at SCORE_W+1 bits.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > (PW+1)'((1 << SCORE_W) - 1)) ? '1 : s[SCORE_W-1:0];
  endfunction

  // Penalty factors from the live inputs, clamped at 0 and CAP.
  always_comb begin
    w_lvl_ok = (int'(bus.level) < NUM_LEVELS);
    w_grace  = w_lvl_ok ? EXW'(bus.level) * EXW'(GRACE_STEP) : '0;
    w_t_exc  = (EXW'(bus.seconds) > w_grace) ? EXW'(bus.seconds) - w_grace : '0;
    w_ft     = (w_t_exc > EXW'(CAP)) ? FACT_W'(CAP) : w_t_exc[FACT_W-1:0];
    w_half   = EXW'(bus.num_of_cards >> 1);
    w_p_exc  = (EXW'(bus.discovered_pairs) > w_half) ? EXW'(bus.discovered_pairs) - w_half : '0;
    w_fp     = (w_p_exc > EXW'(CAP)) ? FACT_W'(CAP) : w_p_exc[FACT_W-1:0];
  end

  // Final score from the captured time product and the fresh pairs product.
  always_comb begin
    w_bonus    = lvl_ok_q ? PW'(lvl_bonus(int'(lvl_q))) : '0;
    w_term_t   = (tp_q >= PW'(MAX_TERM)) ? '0 : PW'(MAX_TERM) - tp_q;
    w_term_p   = (mul_prod >= PW'(MAX_TERM)) ? '0 : PW'(MAX_TERM) - mul_prod;
    w_score    = sat_add(PW'(sat_add(w_bonus, w_term_t)), w_term_p);
    w_best_cur = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (lvl_q == LVL_W'(i)) w_best_cur = best_q[i];
    end
    w_is_rec = lvl_ok_q && (w_score > w_best_cur);
  end

  // Best-score readout for whatever level is presented now.
  always_comb begin
    w_best_rd = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (bus.level == LVL_W'(i)) w_best_rd = best_q[i];
    end
  end

  // Next-state and control; enable low before the result is out aborts.
  always_comb begin
    state_d   = state_q;
    points_d  = points_q;
    calc_d    = 1'b0;
    rec_d     = 1'b0;
    latch_en  = 1'b0;
    best_we   = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        points_d = '0;
        if (bus.enable) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else begin
          latch_en = 1'b1;
          state_d  = S_MUL_T;
        end
      end
      S_MUL_T: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else begin
          mul_start = !mul_busy;
          if (mul_done) state_d = S_MUL_P;
        end
      end
      S_MUL_P: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else begin
          mul_start = !mul_busy;
          if (mul_done) state_d = S_SUM;
        end
      end
      S_SUM: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else begin
          points_d = w_score;
          calc_d   = 1'b1;
          rec_d    = w_is_rec;
          best_we  = w_is_rec;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!bus.enable) begin
          points_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        points_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      points_q <= '0;
      calc_q   <= 1'b0;
      rec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      points_q <= points_d;
      calc_q   <= calc_d;
      rec_q    <= rec_d;
    end
  end

  // Request snapshot so later input changes do not disturb the computation.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q    <= '0;
      lvl_ok_q <= 1'b0;
      ft_q     <= '0;
      fp_q     <= '0;
    end else if (latch_en) begin
      lvl_q    <= bus.level;
      lvl_ok_q <= w_lvl_ok;
      ft_q     <= w_ft;
      fp_q     <= w_fp;
    end
  end

  // Keep the time product before the multiplier is reused for pairs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q <= '0;
    end else if (state_q == S_MUL_P && !mul_busy) begin
      tp_q <= mul_prod;
    end
  end

  // Best score table, written only on a strict improvement.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (rst) begin
        best_q[i] <= '0;
      end else if (best_we && lvl_q == LVL_W'(i)) begin
        best_q[i] <= w_score;
      end
    end
  end

  assign mul_clr = (state_q == S_IDLE);
  assign mul_a   = (state_q == S_MUL_P) ? fp_q : ft_q;

  score_engine_seq_mult #(
    .A_W (FACT_W),
    .P_W (PW),
    .B   (STEP)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (mul_clr),
    .start_i   (mul_start),
    .a_i       (mul_a),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign bus.points            = points_q;
  assign bus.points_calculated = calc_q;
  assign bus.new_record        = rec_q;
  assign bus.best_points       = w_best_rd;

endmodule
`default_nettype wire

// File: tb/tb_score_engine.sv
`default_nettype none
// ============================================================================
//  Module : tb_score_engine
//  Brief  : Self-checking bench for score_engine: directed scenarios followed
//           by randomized requests against a rule-level reference model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_score_engine;
  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   best_m [NL];

  always #5 clk = ~clk;

  score_engine_if #(.LVL_W(2), .CARD_W(6), .SCORE_W(14)) bus ();

  score_engine #(
    .NUM_LEVELS (3), .LVL_W (2), .CARD_W (6), .SCORE_W (14), .FACT_W (6),
    .MAX_TERM (3333), .STEP (101), .CAP (33), .GRACE_STEP (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoring rule written directly from the game definition.
  function automatic int model_score(input int lvl, input int cards, input int pairs, input int secs);
    int bonus, grace, ft, fp, s;
    bonus = (lvl == 1) ? 1515 : (lvl == 2) ? 3333 : 0;
    grace = (lvl < NL) ? lvl * 5 : 0;
    ft = secs - grace;
    if (ft < 0)  ft = 0;
    if (ft > 33) ft = 33;
    fp = pairs - cards / 2;
    if (fp < 0)  fp = 0;
    if (fp > 33) fp = 33;
    s = bonus + (3333 - ft * 101) + (3333 - fp * 101);
    if (s > 16383) s = 16383;
    return s;
  endfunction

  function automatic int model_best(input int lvl);
    return (lvl < NL) ? best_m[lvl] : 0;
  endfunction

  task automatic drive(input int lvl, input int cards, input int pairs, input int secs);
    bus.level            = 2'(lvl);
    bus.num_of_cards     = 6'(cards);
    bus.discovered_pairs = 8'(pairs);
    bus.seconds          = 6'(secs);
  endtask

  // Full request: latency, result, record flag, best readout, pulse width, release.
  task automatic run_req(input string tag, input int lvl, input int cards, input int pairs,
                         input int secs, input bit scramble);
    int exp_pts, exp_rec, lat;
    exp_pts = model_score(lvl, cards, pairs, secs);
    exp_rec = (lvl < NL && exp_pts > best_m[lvl]) ? 1 : 0;
    @(negedge clk);
    drive(lvl, cards, pairs, secs);
    bus.enable = 1'b1;
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1 && scramble) drive($urandom_range(0, 3), $urandom_range(0, 63),
                                    $urandom_range(0, 255), $urandom_range(0, 63));
      if (bus.points_calculated === 1'b1) lat = k;
    end
    check({tag, "_latency"}, lat, 14);
    check({tag, "_points"}, bus.points, exp_pts);
    check({tag, "_new_record"}, bus.new_record, exp_rec);
    if (exp_rec == 1) best_m[lvl] = exp_pts;
    bus.level = 2'(lvl);
    #1;
    check({tag, "_best"}, bus.best_points, model_best(lvl));
    @(posedge clk); #1;
    check({tag, "_pulse_len"}, bus.points_calculated, 0);
    check({tag, "_hold"}, bus.points, exp_pts);
    @(negedge clk);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_zero"}, bus.points, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    for (int i = 0; i < NL; i++) best_m[i] = 0;
    bus.enable = 1'b0;
    drive(0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_points", bus.points, 0);
    check("rst_calc", bus.points_calculated, 0);
    check("rst_rec", bus.new_record, 0);
    check("rst_best", bus.best_points, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios.
    run_req("t1", 0, 16, 8, 0, 1'b0);      // 6666, record
    run_req("t2", 1, 16, 10, 5, 1'b1);     // 7979, record
    run_req("t3", 2, 36, 60, 63, 1'b1);    // both saturated, 3333

    // Abort: enable sampled low at E0+5.
    @(negedge clk);
    drive(2, 36, 0, 0);
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.points_calculated === 1'b1) pulses++;
      if (bus.points !== '0) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_best", bus.best_points, 3333);

    run_req("t4_eq", 0, 16, 8, 0, 1'b0);   // equal to best: not a record
    run_req("t5_eq", 1, 16, 10, 5, 1'b0);
    run_req("t5_low", 1, 16, 8, 20, 1'b1); // 6666 < 7979
    run_req("t6_under", 0, 16, 5, 10, 1'b0); // fp=0, 5656
    run_req("t_badlvl", 3, 10, 9, 12, 1'b0);

    // Reset while the pairs product is being formed.
    @(negedge clk);
    drive(1, 20, 30, 40);
    bus.enable = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mulp_rst_points", bus.points, 0);
    check("mulp_rst_calc", bus.points_calculated, 0);
    check("mulp_rst_rec", bus.new_record, 0);
    for (int l = 0; l < NL; l++) begin
      bus.level = 2'(l);
      #1;
      check("mulp_rst_best", bus.best_points, 0);
      best_m[l] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.enable = 1'b0;
    @(posedge clk);
    run_req("post_rst", 1, 16, 10, 5, 1'b1);

    // Randomized requests, including the out-of-range level.
    for (int n = 0; n < 40; n++) begin
      run_req("rnd", $urandom_range(0, 3), $urandom_range(0, 63),
              $urandom_range(0, 255), $urandom_range(0, 63), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
